mem_access: RTL and testbench

- Memory stage sitting directly downstream of the execute stage.
- Consumes execute's registered outputs (rd select, mem read/write enables, access size, ALU result as address, rs2 as store data).
- Drives a req/gnt/rvalid data-memory port: byte-enable generation and store-lane replication for stores, extraction and sign/zero extension for loads.
- Presents a registered writeback result and a combinational stall back to the pipeline.

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_load_align.sv | 27 ++
 rtl/mem_access.sv | 140 ++++++++++++++
 tb/tb_mem_access.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the memory access stage
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } data_size_e;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - extracts the addressed lane of a load word and sign/zero extends it
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  data_size_e  size,
  input  logic        load_unsigned,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = rdata >> {off, 3'b000};
  assign half_shift = rdata >> {off[1], 4'b0000};

  always_comb begin
    load_data = rdata;
    case (size)
      SIZE_BYTE: load_data = {{24{~load_unsigned & byte_shift[7]}}, byte_shift[7:0]};
      SIZE_HALF: load_data = {{16{~load_unsigned & half_shift[15]}}, half_shift[15:0]};
      default:   load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: req/gnt/rvalid data port, lane steering, writeback register
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are dropped and flagged on misalign_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            sel_rd_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  data_size_e            mem_size_i,
  input  logic                  load_unsigned_i,
  input  logic [31:0]           alu_result_i,
  input  logic [31:0]           rs2_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  misalign_o,
`endif
  output logic [4:0]            sel_rd_o,
  output logic [31:0]           wb_data_o
);

  mem_state_e  state, state_next;
  logic [1:0]  off;
  logic        is_store, is_load, is_mem, misaligned, issue;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign off      = alu_result_i[1:0];
  assign is_store = mem_we_i;
  assign is_load  = mem_re_i & ~mem_we_i;
  assign is_mem   = is_store | is_load;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_mem & (((mem_size_i == SIZE_HALF) & off[0]) |
                                ((mem_size_i == SIZE_WORD) & (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif
  assign issue = is_mem & ~misaligned;

  always_comb begin
    be    = BE_WORD;
    wdata = rs2_i;
    case (mem_size_i)
      SIZE_BYTE: begin
        be    = BE_BYTE << off;
        wdata = {4{rs2_i[7:0]}};
      end
      SIZE_HALF: begin
        be    = BE_HALF << {off[1], 1'b0};
        wdata = {2{rs2_i[15:0]}};
      end
      default: begin
        be    = BE_WORD;
        wdata = rs2_i;
      end
    endcase
  end

  // Upstream holds the op stable while stalled, so attributes only need gating on is_mem.
  assign dmem_addr_o  = is_mem ? {alu_result_i[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be_o    = is_mem ? be : 4'b0000;
  assign dmem_wdata_o = is_mem ? wdata : 32'h0;
  assign dmem_we_o    = dmem_req_o & is_store;

  always_comb begin
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    state_next = state;
    case (state)
      IDLE, WAIT_GNT: begin
        state_next = IDLE;
        if (issue) begin
          dmem_req_o = 1'b1;
          if (!dmem_gnt_i) begin
            state_next = WAIT_GNT;
            stall_o    = 1'b1;
          end else if (is_load) begin
            state_next = WAIT_RVALID;
            stall_o    = 1'b1;
          end
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) state_next = IDLE;
        else               stall_o    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_load_align u_load_align (
    .rdata         (dmem_rdata_i),
    .off           (off),
    .size          (mem_size_i),
    .load_unsigned (load_unsigned_i),
    .load_data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_rd_o  <= 5'd0;
      wb_data_o <= 32'h0;
    end else begin
      state <= state_next;
      if (stall_o) begin
        sel_rd_o <= 5'd0;
      end else if (state == WAIT_RVALID) begin
        sel_rd_o  <= sel_rd_i;
        wb_data_o <= load_data;
      end else if (is_mem) begin
        sel_rd_o <= 5'd0;
      end else begin
        sel_rd_o  <= sel_rd_i;
        wb_data_o <= alu_result_i;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= (state == IDLE) & misaligned;
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - table-driven and directed self-checking bench for mem_access
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  sel_rd_i = '0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  data_size_e  mem_size_i = SIZE_WORD;
  logic        load_unsigned_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] rs2_i = '0;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic [4:0]  sel_rd_o;
  logic [31:0] wb_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_access #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .sel_rd_i        (sel_rd_i),
    .mem_re_i        (mem_re_i),
    .mem_we_i        (mem_we_i),
    .mem_size_i      (mem_size_i),
    .load_unsigned_i (load_unsigned_i),
    .alu_result_i    (alu_result_i),
    .rs2_i           (rs2_i),
    .stall_o         (stall_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
`endif
    .sel_rd_o        (sel_rd_o),
    .wb_data_o       (wb_data_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sel_rd_i = '0; mem_re_i = 1'b0; mem_we_i = 1'b0; mem_size_i = SIZE_WORD;
    load_unsigned_i = 1'b0; alu_result_i = '0; rs2_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        re;
    logic        we;
    data_size_e  size;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  localparam int NV = 12;
  vec_t v[NV];

  initial begin
    logic is_ld, is_st, is_mem;
    logic [31:0] exp_addr;

    v[0]  = '{5'd5,  1'b0, 1'b0, SIZE_WORD, 1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF};
    v[1]  = '{5'd0,  1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h00001001, 32'h000000A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'hDEADBEEF};
    v[2]  = '{5'd0,  1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h00002002, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'hDEADBEEF};
    v[3]  = '{5'd0,  1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h00003000, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'hDEADBEEF};
    v[4]  = '{5'd6,  1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h00003003, 32'h0000007F, 32'h0,        4'b1000, 32'h7F7F7F7F, 32'hDEADBEEF};
    v[5]  = '{5'd7,  1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h00001003, 32'h0,        32'h80AABBCC, 4'b1000, 32'h0,        32'hFFFFFF80};
    v[6]  = '{5'd8,  1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h00004002, 32'h0,        32'hF00D0000, 4'b1100, 32'h0,        32'h0000F00D};
    v[7]  = '{5'd10, 1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h00004000, 32'h0,        32'h12348001, 4'b0011, 32'h0,        32'hFFFF8001};
    v[8]  = '{5'd11, 1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h00005001, 32'h0,        32'h11229A44, 4'b0010, 32'h0,        32'h0000009A};
    v[9]  = '{5'd12, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h00006004, 32'h0,        32'h89ABCDEF, 4'b1111, 32'h0,        32'h89ABCDEF};
    v[10] = '{5'd0,  1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h00000055, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00000055};
    v[11] = '{5'd13, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h12345678, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h12345678};

    // Reset state
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_sel_rd", 32'(sel_rd_o), 32'd0);
    check("reset_wb", wb_data_o, 32'h0);
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_req", 32'(dmem_req_o), 32'd0);
    check("reset_addr", dmem_addr_o, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("reset_misalign", 32'(misalign_o), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back ops, loads granted at once and answered the next cycle
    for (int i = 0; i < NV; i++) begin
      is_st  = v[i].we;
      is_ld  = v[i].re & ~v[i].we;
      is_mem = is_st | is_ld;
      exp_addr = is_mem ? {v[i].alu[31:2], 2'b00} : 32'h0;
      @(negedge clk);
      sel_rd_i = v[i].rd; mem_re_i = v[i].re; mem_we_i = v[i].we; mem_size_i = v[i].size;
      load_unsigned_i = v[i].uns; alu_result_i = v[i].alu; rs2_i = v[i].rs2;
      dmem_gnt_i = is_mem; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
      #1;
      check($sformatf("v%0d_req", i), 32'(dmem_req_o), 32'(is_mem));
      check($sformatf("v%0d_we", i), 32'(dmem_we_o), 32'(is_st));
      check($sformatf("v%0d_addr", i), dmem_addr_o, exp_addr);
      check($sformatf("v%0d_be", i), 32'(dmem_be_o), 32'(v[i].be));
      check($sformatf("v%0d_stall", i), 32'(stall_o), 32'(is_ld));
      if (is_st) check($sformatf("v%0d_wdata", i), dmem_wdata_o, v[i].wdata);
      if (is_ld) begin
        @(posedge clk); #1;
        check($sformatf("v%0d_sel_rd_stall", i), 32'(sel_rd_o), 32'd0);
        @(negedge clk);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = v[i].rdata;
        #1;
        check($sformatf("v%0d_req_rvalid", i), 32'(dmem_req_o), 32'd0);
        check($sformatf("v%0d_stall_rvalid", i), 32'(stall_o), 32'd0);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_sel_rd", i), 32'(sel_rd_o), is_st ? 32'd0 : 32'(v[i].rd));
      check($sformatf("v%0d_wb", i), wb_data_o, v[i].wb);
    end

    // Grant delay with stray rvalid in IDLE/WAIT_GNT and stray gnt in WAIT_RVALID
    @(negedge clk);
    idle_inputs();
    sel_rd_i = 5'd9; mem_re_i = 1'b1; mem_size_i = SIZE_WORD; alu_result_i = 32'h00008000;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("gd%0d_req", k), 32'(dmem_req_o), 32'd1);
      check($sformatf("gd%0d_addr", k), dmem_addr_o, 32'h00008000);
      check($sformatf("gd%0d_stall", k), 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      check($sformatf("gd%0d_sel_rd", k), 32'(sel_rd_o), 32'd0);
      check($sformatf("gd%0d_wb", k), wb_data_o, 32'h12345678);
      @(negedge clk);
    end
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    #1;
    check("gd_gnt_req", 32'(dmem_req_o), 32'd1);
    check("gd_gnt_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    #1;
    check("gd_wr_req", 32'(dmem_req_o), 32'd0);
    check("gd_wr_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    check("gd_wr_sel_rd", 32'(sel_rd_o), 32'd0);
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
    #1;
    check("gd_rv_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("gd_sel_rd", 32'(sel_rd_o), 32'd9);
    check("gd_wb", wb_data_o, 32'h0BADF00D);

    // Reset while waiting for rvalid; the late rvalid must be dropped
    @(negedge clk);
    idle_inputs();
    sel_rd_i = 5'd3; mem_re_i = 1'b1; mem_size_i = SIZE_BYTE; alu_result_i = 32'h00000100;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0; rst = 1'b1;
    #1;
    check("rst_pre_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    check("rst_sel_rd", 32'(sel_rd_o), 32'd0);
    check("rst_wb", wb_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    #1;
    check("rst_late_stall", 32'(stall_o), 32'd0);
    check("rst_late_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    check("rst_late_sel_rd", 32'(sel_rd_o), 32'd0);
    check("rst_late_wb", wb_data_o, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load is dropped and flagged for one cycle
    @(negedge clk);
    idle_inputs();
    sel_rd_i = 5'd4; mem_re_i = 1'b1; mem_size_i = SIZE_WORD; alu_result_i = 32'h00001001;
    dmem_gnt_i = 1'b1;
    #1;
    check("mis_req", 32'(dmem_req_o), 32'd0);
    check("mis_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("mis_flag", 32'(misalign_o), 32'd1);
    check("mis_sel_rd", 32'(sel_rd_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("mis_flag_clear", 32'(misalign_o), 32'd0);
`else
    // Misaligned half store truncates to the upper half lanes
    @(negedge clk);
    idle_inputs();
    mem_we_i = 1'b1; mem_size_i = SIZE_HALF; alu_result_i = 32'h00004003; rs2_i = 32'h00001234;
    dmem_gnt_i = 1'b1;
    #1;
    check("trunc_addr", dmem_addr_o, 32'h00004000);
    check("trunc_be", 32'(dmem_be_o), 32'(4'b1100));
    check("trunc_wdata", dmem_wdata_o, 32'h12341234);
    check("trunc_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("trunc_sel_rd", 32'(sel_rd_o), 32'd0);
`endif

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
